// File: rtl/fsb_term_ctl.sv
// MC68HC000 bus-cycle termination controller: picks a source at cycle start, waits out its
// minimum wait states, then ends the cycle with nDTACK, nVPA or nBERR (timeout).
module fsb_term_ctl #(
   parameter int unsigned           NSRC    = 4,
   parameter int unsigned           WAITW   = 4,
   parameter logic [NSRC*WAITW-1:0] WS      = '0,
   parameter int unsigned           TOW     = 8,
   parameter int unsigned           TIMEOUT = 255
) (
   input  logic            FCLK,
   input  logic            nRESET,
   input  logic            nAS,
   input  logic [NSRC-1:0] CS,
   input  logic [NSRC-1:0] RDY,
   input  logic            IACS,
   output logic            BACT,
   output logic            nDTACK,
   output logic            nVPA,
   output logic            nBERR,
   output logic [NSRC-1:0] TERM
);

   localparam int unsigned    TO_M1   = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
   localparam logic [TOW-1:0] TO_LAST = TOW'(TO_M1);

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StHold
   } state_e;

   state_e             state_q, state_d;
   logic [NSRC-1:0]    sel_q, sel_d;
   logic               iack_q, iack_d;
   logic [WAITW-1:0]   wcnt_q, wcnt_d;
   logic [TOW-1:0]     tcnt_q, tcnt_d;
   logic               dtack_q, dtack_d;
   logic               vpa_q, vpa_d;
   logic               berr_q, berr_d;
   logic [NSRC-1:0]    term_q, term_d;
   logic               asrf_q;

   logic [NSRC-1:0]    cs_oh;
   logic [WAITW-1:0]   cs_ws;
   logic               rdy_hit;

   // Lowest-index chip select wins; the source is kept one-hot so TERM is a straight copy.
   always_comb begin
      cs_oh = '0;
      cs_ws = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (CS[i]) begin
            cs_oh    = '0;
            cs_oh[i] = 1'b1;
            cs_ws    = WS[i*WAITW +: WAITW];
         end
      end
   end

   assign rdy_hit = |(RDY & sel_q);

   always_ff @(negedge FCLK or negedge nRESET) begin
      if (!nRESET) begin
         asrf_q <= 1'b0;
      end else begin
         asrf_q <= !nAS;
      end
   end

   always_ff @(posedge FCLK or negedge nRESET) begin
      if (!nRESET) begin
         state_q <= StIdle;
         sel_q   <= '0;
         iack_q  <= 1'b0;
         wcnt_q  <= '0;
         tcnt_q  <= '0;
         dtack_q <= 1'b0;
         vpa_q   <= 1'b0;
         berr_q  <= 1'b0;
         term_q  <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         iack_q  <= iack_d;
         wcnt_q  <= wcnt_d;
         tcnt_q  <= tcnt_d;
         dtack_q <= dtack_d;
         vpa_q   <= vpa_d;
         berr_q  <= berr_d;
         term_q  <= term_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      iack_d  = iack_q;
      wcnt_d  = wcnt_q;
      tcnt_d  = tcnt_q;
      dtack_d = dtack_q;
      vpa_d   = vpa_q;
      berr_d  = berr_q;
      term_d  = term_q;

      unique case (state_q)
         StIdle: begin
            dtack_d = 1'b0;
            vpa_d   = 1'b0;
            berr_d  = 1'b0;
            term_d  = '0;
            if (!nAS) begin
               state_d = StWait;
               sel_d   = cs_oh;
               iack_d  = IACS;
               wcnt_d  = cs_ws;
               tcnt_d  = '0;
            end
         end

         StWait: begin
            if (nAS) begin
               // Aborted cycle: drop back without asserting anything.
               state_d = StIdle;
            end else begin
               if (wcnt_q != '0) begin
                  wcnt_d = wcnt_q - 1'b1;
               end else if (rdy_hit) begin
                  state_d = StHold;
                  dtack_d = !iack_q;
                  vpa_d   = iack_q;
                  term_d  = sel_q;
               end else if ((TIMEOUT != 0) && (tcnt_q == TO_LAST)) begin
                  state_d = StHold;
                  berr_d  = 1'b1;
                  term_d  = '0;
               end
               if (tcnt_q != '1) begin
                  tcnt_d = tcnt_q + 1'b1;
               end
            end
         end

         StHold: begin
            if (nAS) begin
               state_d = StIdle;
               dtack_d = 1'b0;
               vpa_d   = 1'b0;
               berr_d  = 1'b0;
               term_d  = '0;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Strobes are gated by nAS so they release the moment the CPU ends the cycle.
   assign BACT   = !nAS || asrf_q;
   assign nDTACK = !(dtack_q && !nAS);
   assign nVPA   = !(vpa_q && !nAS);
   assign nBERR  = !(berr_q && !nAS);
   assign TERM   = nAS ? '0 : term_q;

   strobe_exclusive_a : assert property (@(posedge FCLK) disable iff (!nRESET)
      $onehot0({dtack_q, vpa_q, berr_q}));

endmodule
